// File: rtl/multi_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl_if
// Brief    : Instruction, branch, memory and control-output bundle of the
//            multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_cycle_ctrl_if;
  logic        Start;
  logic [8:0]  InstIn;
  logic        BranchCond;
  logic [11:0] BrTarget;
  logic        MemReady;
  logic [11:0] PC;
  logic        Format;
  logic        Load;
  logic        ALUSrc;
  logic        Branch;
  logic        Copy;
  logic        Move;
  logic        BranchResult;
  logic        RegWrite;
  logic        MemWrite;
  logic        MemRead;
  logic        Done;
  logic [15:0] InstCount;
  logic [2:0]  State;

  modport slave (
    input  Start, InstIn, BranchCond, BrTarget, MemReady,
    output PC, Format, Load, ALUSrc, Branch, Copy, Move, BranchResult,
    output RegWrite, MemWrite, MemRead, Done, InstCount, State
  );

  modport master (
    output Start, InstIn, BranchCond, BrTarget, MemReady,
    input  PC, Format, Load, ALUSrc, Branch, Copy, Move, BranchResult,
    input  RegWrite, MemWrite, MemRead, Done, InstCount, State
  );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl
// Brief    : Multi-cycle processor controller: FSM, instruction register,
//            program counter, retired-instruction counter and datapath selects.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl (
  input  wire logic          Clk,
  input  wire logic          Reset,
  multi_cycle_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADDI   = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;
  localparam logic [2:0] OP_COPY   = 3'b100;
  localparam logic [2:0] OP_MOVE   = 3'b101;
  localparam logic [2:0] OP_BRANCH = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [8:0]  ir_q, ir_d;
  logic [15:0] cnt_q, cnt_d;

  logic [2:0]  op;
  logic        retire;
  logic        take_branch;
  logic        count_inc;
  logic        active;

  assign op = ir_q[8:6];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= 12'd0;
      ir_q    <= 9'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    retire      = 1'b0;
    take_branch = 1'b0;
    count_inc   = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.Start) begin
          state_d = S_FETCH;
          pc_d    = 12'd0;
          cnt_d   = 16'd0;
        end
      end
      S_FETCH: begin
        ir_d    = bus.InstIn;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op == OP_HALT) begin
          state_d   = S_HALT;
          count_inc = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_LOAD || op == OP_STORE) begin
          state_d = S_MEM;
        end else if (op == OP_BRANCH) begin
          state_d     = S_FETCH;
          retire      = 1'b1;
          take_branch = bus.BranchCond;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.MemReady) begin
          if (op == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // PC and counter only move when an instruction actually completes
    if (retire) begin
      pc_d = take_branch ? bus.BrTarget : pc_q + 12'd1;
    end
    if ((retire || count_inc) && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                  (state_q == S_MEM)    || (state_q == S_WB);

  assign bus.ALUSrc       = active && (op == OP_ADDI);
  assign bus.Load         = active && (op == OP_LOAD);
  assign bus.Copy         = active && (op == OP_COPY);
  assign bus.Move         = active && (op == OP_MOVE);
  assign bus.Branch       = active && (op == OP_BRANCH);
  assign bus.Format       = active && ir_q[5];
  assign bus.BranchResult = (state_q == S_EXEC) && (op == OP_BRANCH) && bus.BranchCond;
  assign bus.RegWrite     = (state_q == S_WB);
  assign bus.MemRead      = (state_q == S_MEM) && (op == OP_LOAD);
  assign bus.MemWrite     = (state_q == S_MEM) && (op == OP_STORE);
  assign bus.Done         = (state_q == S_HALT);
  assign bus.PC           = pc_q;
  assign bus.InstCount    = cnt_q;
  assign bus.State        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_ctrl
// Brief    : Instruction-level scoreboard bench for multi_cycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  multi_cycle_ctrl_if bus();

  multi_cycle_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0]  instr;
    int          cycles;
    logic [11:0] pc_after;
    logic [15:0] cnt_after;
    int          waits;
    bit          cond;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          trace_en = 1'b0;
  int          trace_q[$];
  int          exp_trace[7] = '{1, 2, 3, 5, 1, 2, 6};
  logic [11:0] m_pc;
  logic [15:0] m_cnt;

  // per-instruction observations gathered by the monitor
  bit in_instr = 1'b0;
  int cyc, n_rw, n_mr, n_mw, n_br, n_as, n_ld, n_cp, n_mv, n_bra, n_fmt, fetch_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic junk();
    bus.Start      = 1'($urandom_range(0, 1));
    bus.MemReady   = 1'($urandom_range(0, 1));
    bus.BranchCond = 1'($urandom_range(0, 1));
    bus.BrTarget   = 12'($urandom_range(0, 4095));
    bus.InstIn     = 9'($urandom_range(0, 511));
  endtask

  // DUT must be in IDLE or HALT for the current cycle
  task automatic start_prog();
    junk();
    bus.Start = 1'b1;
    tick();
    m_pc  = 12'd0;
    m_cnt = 16'd0;
  endtask

  // Issue one instruction while the DUT sits in FETCH; model it from the latency/PC rules
  task automatic exec_instr(input logic [8:0] instr, input bit cond, input logic [11:0] tgt,
                            input int waits);
    exp_t     e;
    bit [2:0] op;
    op = instr[8:6];
    case (op)
      3'b110:  e.cycles = 3;
      3'b010:  e.cycles = 5 + waits;
      3'b011:  e.cycles = 4 + waits;
      3'b111:  e.cycles = 2;
      default: e.cycles = 4;
    endcase
    if (op == 3'b110 && cond) m_pc = tgt;
    else if (op != 3'b111)    m_pc = m_pc + 12'd1;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    e.instr = instr; e.pc_after = m_pc; e.cnt_after = m_cnt; e.waits = waits; e.cond = cond;
    if (mon_en) sbq.push_back(e);

    junk(); bus.InstIn = instr; tick();
    junk(); tick();
    if (op == 3'b111) begin
      junk(); bus.Start = 1'b0;
      return;
    end
    junk();
    if (op == 3'b110) begin
      bus.BranchCond = cond;
      bus.BrTarget   = tgt;
    end
    tick();
    if (op == 3'b010 || op == 3'b011) begin
      for (int i = 0; i <= waits; i++) begin
        junk(); bus.MemReady = (i == waits); tick();
      end
    end
    if (op != 3'b110 && op != 3'b011) begin
      junk(); tick();
    end
  endtask

  task automatic finalize();
    exp_t     e;
    bit [2:0] op;
    int       n;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_underflow actual=empty required=entry");
      return;
    end
    e  = sbq.pop_front();
    op = e.instr[8:6];
    n  = e.cycles - 1;
    check("cycles",       32'(cyc),           32'(e.cycles));
    check("pc",           32'(bus.PC),        32'(e.pc_after));
    check("instcount",    32'(bus.InstCount), 32'(e.cnt_after));
    check("regwrite",     32'(n_rw),  (op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ? 1 : 0);
    check("memread",      32'(n_mr),  (op == 3'b010) ? 32'(e.waits + 1) : 0);
    check("memwrite",     32'(n_mw),  (op == 3'b011) ? 32'(e.waits + 1) : 0);
    check("branchresult", 32'(n_br),  (op == 3'b110 && e.cond) ? 1 : 0);
    check("alusrc",       32'(n_as),  (op == 3'b001) ? 32'(n) : 0);
    check("load",         32'(n_ld),  (op == 3'b010) ? 32'(n) : 0);
    check("copy",         32'(n_cp),  (op == 3'b100) ? 32'(n) : 0);
    check("move",         32'(n_mv),  (op == 3'b101) ? 32'(n) : 0);
    check("branch",       32'(n_bra), (op == 3'b110) ? 32'(n) : 0);
    check("format",       32'(n_fmt), e.instr[5] ? 32'(n) : 0);
    check("fetch_quiet",  32'(fetch_bad), 0);
  endtask

  always @(negedge Clk) begin
    if (trace_en) trace_q.push_back(int'(bus.State));
    if (!mon_en) begin
      in_instr = 1'b0;
    end else if (bus.State == 3'd1 || bus.Done) begin
      if (in_instr) finalize();
      in_instr = 1'b0;
      if (bus.State == 3'd1) begin
        in_instr = 1'b1;
        cyc = 1; n_rw = 0; n_mr = 0; n_mw = 0; n_br = 0; n_as = 0;
        n_ld = 0; n_cp = 0; n_mv = 0; n_bra = 0; n_fmt = 0;
        fetch_bad = int'(bus.Load | bus.ALUSrc | bus.Copy | bus.Move | bus.Branch |
                         bus.Format | bus.BranchResult | bus.RegWrite | bus.MemRead |
                         bus.MemWrite | bus.Done);
      end
    end else if (in_instr) begin
      cyc++;
      n_rw  += int'(bus.RegWrite);
      n_mr  += int'(bus.MemRead);
      n_mw  += int'(bus.MemWrite);
      n_br  += int'(bus.BranchResult);
      n_as  += int'(bus.ALUSrc);
      n_ld  += int'(bus.Load);
      n_cp  += int'(bus.Copy);
      n_mv  += int'(bus.Move);
      n_bra += int'(bus.Branch);
      n_fmt += int'(bus.Format);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check_halt(input string name, input logic [11:0] pc, input logic [15:0] cnt);
    @(negedge Clk); #1;
    check({name, "_done"}, 32'(bus.Done),      1);
    check({name, "_pc"},   32'(bus.PC),        32'(pc));
    check({name, "_cnt"},  32'(bus.InstCount), 32'(cnt));
  endtask

  initial begin
    Reset = 1'b1;
    junk();
    bus.Start = 1'b1;
    tick(); tick();
    @(negedge Clk);
    check("rst_state", 32'(bus.State),     0);
    check("rst_pc",    32'(bus.PC),        0);
    check("rst_cnt",   32'(bus.InstCount), 0);
    check("rst_done",  32'(bus.Done),      0);
    check("rst_outs",  32'(bus.Load | bus.ALUSrc | bus.Copy | bus.Move | bus.Branch |
                           bus.Format | bus.BranchResult | bus.RegWrite |
                           bus.MemRead | bus.MemWrite), 0);
    Reset = 1'b0;
    bus.Start = 1'b0;
    tick();

    mon_en = 1'b1;
    // ADD then HALT with state trace
    start_prog();
    trace_en = 1'b1;
    exec_instr(9'h000, 1'b0, 12'd0, 0);
    exec_instr(9'h1C0, 1'b0, 12'd0, 0);
    check_halt("add_halt", 12'd1, 16'd2);
    trace_en = 1'b0;
    check("trace_len", 32'(trace_q.size()), 7);
    for (int i = 0; i < 7 && i < trace_q.size(); i++)
      check($sformatf("trace_%0d", i), 32'(trace_q[i]), 32'(exp_trace[i]));

    start_prog();
    exec_instr(9'h180, 1'b1, 12'h2A5, 0);
    exec_instr(9'h1C0, 1'b0, 12'd0, 0);
    check_halt("br_taken", 12'h2A5, 16'd2);

    start_prog();
    exec_instr(9'h180, 1'b0, 12'h2A5, 0);
    exec_instr(9'h1C0, 1'b0, 12'd0, 0);
    check_halt("br_not_taken", 12'h001, 16'd2);

    start_prog();
    exec_instr(9'h080, 1'b0, 12'd0, 3);
    exec_instr(9'h1C0, 1'b0, 12'd0, 0);
    check_halt("load_stall", 12'h001, 16'd2);

    start_prog();
    exec_instr(9'h180, 1'b1, 12'hFFF, 0);
    exec_instr(9'h140, 1'b0, 12'd0, 0);
    exec_instr(9'h1C0, 1'b0, 12'd0, 0);
    check_halt("pc_wrap", 12'h000, 16'd3);

    for (int p = 0; p < 6; p++) begin
      start_prog();
      for (int k = 0; k < 25; k++)
        exec_instr({3'($urandom_range(0, 6)), 6'($urandom_range(0, 63))},
                   1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                   int'($urandom_range(0, 3)));
      exec_instr({3'b111, 6'($urandom_range(0, 63))}, 1'b0, 12'd0, 0);
    end
    @(negedge Clk); #1;
    check("sb_drain", 32'(sbq.size()), 0);
    mon_en = 1'b0;

    // Start pulses during EXEC/WB are ignored; Start in HALT restarts
    start_prog();
    junk(); bus.InstIn = 9'h000; tick();
    junk(); tick();
    junk(); bus.Start = 1'b1;
    @(negedge Clk);
    check("exec_state", 32'(bus.State), 3);
    tick();
    @(negedge Clk);
    check("start_ign_state", 32'(bus.State),     5);
    check("start_ign_pc",    32'(bus.PC),        0);
    check("start_ign_cnt",   32'(bus.InstCount), 0);
    junk(); bus.Start = 1'b1; tick();
    @(negedge Clk);
    check("retire_state", 32'(bus.State),     1);
    check("retire_pc",    32'(bus.PC),        1);
    check("retire_cnt",   32'(bus.InstCount), 1);
    m_pc = 12'd1; m_cnt = 16'd1;
    exec_instr(9'h1C0, 1'b0, 12'd0, 0);
    check_halt("halt2", 12'd1, 16'd2);
    bus.Start = 1'b1;
    tick();
    @(negedge Clk);
    check("restart_state", 32'(bus.State),     1);
    check("restart_pc",    32'(bus.PC),        0);
    check("restart_cnt",   32'(bus.InstCount), 0);
    check("restart_done",  32'(bus.Done),      0);

    // Reset during a STORE memory wait
    m_pc = 12'd0; m_cnt = 16'd0;
    exec_instr(9'h000, 1'b0, 12'd0, 0);
    exec_instr(9'h000, 1'b0, 12'd0, 0);
    junk(); bus.InstIn = 9'h0C0; tick();
    junk(); tick();
    junk(); tick();
    junk(); bus.MemReady = 1'b0;
    @(negedge Clk);
    check("mem_state",    32'(bus.State),     4);
    check("mem_memwrite", 32'(bus.MemWrite),  1);
    check("mem_pc",       32'(bus.PC),        2);
    check("mem_cnt",      32'(bus.InstCount), 2);
    Reset = 1'b1; bus.Start = 1'b1; bus.MemReady = 1'b1;
    tick();
    @(negedge Clk);
    check("midrst_state",    32'(bus.State),     0);
    check("midrst_memwrite", 32'(bus.MemWrite),  0);
    check("midrst_pc",       32'(bus.PC),        0);
    check("midrst_cnt",      32'(bus.InstCount), 0);
    check("midrst_done",     32'(bus.Done),      0);
    Reset = 1'b0; bus.Start = 1'b0;
    tick();
    @(negedge Clk);
    check("post_rst_idle", 32'(bus.State), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL use one clock `Clk`; reset `Reset` is synchronous and active-high.
REQ-002 Ports SHALL be:
- `Clk` in 1: clock.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: begin execution at PC 0.
- `InstIn` in 9: instruction at `PC`.
- `BranchCond` in 1: ALU branch flag.
- `BrTarget` in 12: branch target from LUT.
- `MemReady` in 1: data-memory access complete.
- `PC` out 12: program counter.
- `Format`, `Load`, `ALUSrc`, `Branch`, `Copy`, `Move`, `BranchResult` out 1 each: datapath mux selects.
- `RegWrite`, `MemWrite`, `MemRead` out 1 each: strobes.
- `Done` out 1: halted.
- `InstCount` out 16: retired instructions.
- `State` out 3: FSM state, for debug.

Function
REQ-003 FSM states and encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; encoding 7 is unreachable and SHALL go to IDLE.
REQ-004 In FETCH, the block SHALL latch `InstIn` into IR and then go to DECODE.
- opcode = IR[8:6].
- `Format` = IR[5].
REQ-005 Opcode classes SHALL be:
- 000 ADD
- 001 ADDI
- 010 LOAD
- 011 STORE
- 100 COPY
- 101 MOVE
- 110 BRANCH
- 111 HALT
REQ-006 DECODE SHALL go to HALT for opcode 111 and to EXEC otherwise.
REQ-007 EXEC SHALL go next as follows:
- LOAD/STORE: to MEM.
- BRANCH: to FETCH.
- All others: to WB.
REQ-008 MEM SHALL stay in MEM while `MemReady`=0. When `MemReady`=1 it SHALL go to WB for LOAD and to FETCH for STORE.
REQ-009 WB SHALL always go to FETCH.
REQ-010 Total latency SHALL be:
- ADD, ADDI, COPY, MOVE: 4 cycles.
- BRANCH: 3 cycles.
- LOAD: 5 cycles plus wait cycles.
- STORE: 4 cycles plus wait cycles.
REQ-011 Select outputs SHALL be driven from IR in DECODE, EXEC, MEM and WB, and SHALL be 0 in all other states:
- `ALUSrc` = (op==001).
- `Load` = (op==010).
- `Copy` = (op==100).
- `Move` = (op==101).
- `Branch` = (op==110).
- `Format` = IR[5].
REQ-012 `BranchResult` SHALL be 1 only in EXEC of BRANCH when `BranchCond`=1.
REQ-013 Strobe outputs SHALL be:
- `RegWrite`: 1 only in WB.
- `MemRead`: 1 in every MEM cycle of LOAD.
- `MemWrite`: 1 in every MEM cycle of STORE.
REQ-014 PC SHALL update only on the retiring transition into FETCH:
- BRANCH: `BrTarget` if `BranchCond`=1 in EXEC, else PC+1.
- All others: PC+1.
REQ-015 PC+1 SHALL be modulo 4096, so 0xFFF wraps to 0x000.
REQ-016 `InstCount` SHALL increment by 1 on every retiring transition into FETCH and on DECODE→HALT, and SHALL saturate at 0xFFFF.
REQ-017 In IDLE, `Start`=1 SHALL load PC=0 and `InstCount`=0 and go to FETCH.
REQ-018 `Start` SHALL be ignored in FETCH through WB.
REQ-019 `Done` SHALL be 1 exactly while in HALT.
REQ-020 In HALT, `Start`=1 SHALL behave as in IDLE: PC=0, `InstCount`=0, go to FETCH.
REQ-021 `MemReady` SHALL be ignored outside MEM.
REQ-022 `BranchCond` SHALL be sampled only in EXEC of BRANCH.

Reset
REQ-023 `Reset`=1 at a clock edge SHALL force:
- State=IDLE.
- PC=0, IR=0, `InstCount`=0.
- All selects, strobes and `Done` = 0 from the next cycle.
REQ-024 `Reset` SHALL take priority over `Start` and over any in-flight instruction, including a MEM wait. No strobe SHALL assert in the cycle after reset.

Verification
REQ-025 ADD then HALT:
- Stimulus: Reset, then `Start` pulse; ROM[0]=0x000 (ADD), ROM[1]=0x1C0 (HALT).
- Required: states 1,2,3,5,1,2,6; `RegWrite`=1 for one cycle; `Done`=1 with PC=1 and `InstCount`=2.
REQ-026 Taken branch:
- Stimulus: ROM[0]=0x180 (BRANCH), `BranchCond`=1, `BrTarget`=0x2A5.
- Required: `Branch`=1 in DECODE/EXEC; `BranchResult`=1 in EXEC only; PC=0x2A5 after 3 cycles.
- Repeat with `BranchCond`=0: required PC=1.
REQ-027 LOAD with memory stall:
- Stimulus: ROM[0]=0x080 (LOAD); `MemReady` held 0 for 3 MEM cycles, then 1.
- Required: `MemRead`=1 for 4 cycles; `Load`=1 in DECODE through WB; `RegWrite` pulses once; 8 cycles total; PC=1.
REQ-028 PC wrap:
- Stimulus: force PC=0xFFF via branch `BrTarget`=0xFFF, then execute MOVE (0x140) at 0xFFF.
- Required: PC=0x000 after retire; `Move`=1 during DECODE/EXEC/WB.
REQ-029 Reset mid-operation:
- Stimulus: assert `Reset` during a STORE MEM wait with `MemWrite`=1.
- Required: next cycle State=0, `MemWrite`=0, PC=0, `InstCount`=0; a `Start` in the same cycle as `Reset` is ignored.
REQ-030 Start ignored / restart from HALT:
- Stimulus: `Start` pulse during EXEC.
- Required: no effect on State, PC or `InstCount`.
- Stimulus: `Start` in HALT.
- Required: restart at PC=0, `InstCount`=0, `Done`=0 next cycle.
